// File: rtl/pattern_sweep_pkg.sv
// pattern_sweep_pkg: shared state type, MISR constants and Gray helper for the pattern sweep engine.
package pattern_sweep_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} sweep_state_t;
    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [63:0] SIG_SEED = '1;
    function automatic logic [15:0] gray_of(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/sweep_misr.sv
// sweep_misr: multiple-input signature register folding one response word per enabled cycle.
module sweep_misr
    import pattern_sweep_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int OUT_W = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [OUT_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);
    localparam logic [SIG_W-1:0] POLY = SIG_W'(SIG_POLY);
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;
    assign w_next = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(i_data);
    assign o_sig = r_sig;
    always_ff @(posedge CK or negedge reset) begin
        if (!reset)
            r_sig <= '0;
        else if (i_clear)
            r_sig <= SIG_W'(SIG_SEED);
        else if (i_en)
            r_sig <= w_next;
    end
endmodule

// File: rtl/pattern_sweep_capture.sv
// pattern_sweep_capture: drives every input pattern (binary or Gray) onto a test core, captures
// each settled response as a valid/ready record and compacts the responses into a MISR signature.
module pattern_sweep_capture
    import pattern_sweep_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int SIG_W  = 16
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [IN_W-1:0]  rec_pattern,
    output logic [OUT_W-1:0] rec_resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);
    localparam int STW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [IN_W:0] LAST = {1'b0, {IN_W{1'b1}}};
    sweep_state_t     r_state;
    logic [IN_W:0]    r_cnt;
    logic [STW-1:0]   r_set;
    logic             r_mode;
    logic [IN_W-1:0]  r_stim;
    logic [IN_W-1:0]  r_pat;
    logic [OUT_W-1:0] r_resp;
    logic [IN_W:0]    w_cnt_inc;
    logic [IN_W-1:0]  w_next_pat;
    logic             w_go;
    logic             w_xfer;
    logic             w_settled;
    assign w_go       = r_state == IDLE && start;
    assign w_xfer     = r_state == EMIT && rec_ready && !abort;
    assign w_settled  = r_set == STW'(SETTLE - 1);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_next_pat = r_mode ? IN_W'(gray_of(16'(w_cnt_inc[IN_W-1:0]))) : w_cnt_inc[IN_W-1:0];
    assign stim        = r_stim;
    assign rec_pattern = r_pat;
    assign rec_resp    = r_resp;
    assign rec_valid   = r_state == EMIT;
    assign busy        = r_state == APPLY || r_state == EMIT;
    assign done        = r_state == DONE;
    // Abort outranks everything, including a transfer landing on the same edge.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_set   <= '0;
            r_mode  <= 1'b0;
            r_stim  <= '0;
            r_pat   <= '0;
            r_resp  <= '0;
        end else if (abort && r_state != IDLE) begin
            r_state <= IDLE;
            r_stim  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= APPLY;
                    r_cnt   <= '0;
                    r_set   <= '0;
                    r_mode  <= mode;
                    r_stim  <= '0;
                end
                APPLY: if (w_settled) begin
                    r_state <= EMIT;
                    r_set   <= '0;
                    r_pat   <= r_stim;
                    r_resp  <= resp;
                end else begin
                    r_set <= r_set + 1'b1;
                end
                EMIT: if (rec_ready) begin
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_stim  <= '0;
                    end else begin
                        r_state <= APPLY;
                        r_cnt   <= w_cnt_inc;
                        r_stim  <= w_next_pat;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    sweep_misr #(.SIG_W(SIG_W), .OUT_W(OUT_W)) u_misr (
        .CK(CK),
        .reset(reset),
        .i_clear(w_go),
        .i_en(w_xfer),
        .i_data(r_resp),
        .o_sig(signature)
    );
endmodule

// File: tb/tb_pattern_sweep_capture.sv
// tb_pattern_sweep_capture: directed checks of the sweep engine against an AND3 core
// and a two-stage registered core with a longer settle time.
module tb_pattern_sweep_capture;
    logic        CK = 0, reset = 0, start = 0, mode = 0, abort = 0, rec_ready = 1, inject = 0;
    logic [2:0]  stim, rec_pattern;
    logic        resp, rec_valid, rec_resp, busy, done;
    logic [15:0] signature;
    logic        start2 = 0, mode2 = 0, abort2 = 0, rec_ready2 = 1;
    logic [2:0]  stim2, rec_pattern2;
    logic [1:0]  resp2, rec_resp2, d1, d2;
    logic        rec_valid2, busy2, done2;
    logic [15:0] signature2;
    int n_pass = 0, n_total = 0;
    logic [2:0]  pats [8];
    logic [1:0]  rsps [8];
    int n_rec, done_cyc, n_stall;
    logic        stall_bad, busy_at_done, done_after;
    logic [15:0] sig_start, sig_at_done;
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    always #5 CK = ~CK;

    assign resp = (&stim) ^ (inject && stim == 3'd5);

    function automatic logic [1:0] core2(input logic [2:0] p);
        return {(p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]), ^p};
    endfunction

    always @(posedge CK) begin
        d1 <= core2(stim2);
        d2 <= d1;
    end
    assign resp2 = d2;

    pattern_sweep_capture #(.IN_W(3), .OUT_W(1), .SETTLE(1), .SIG_W(16)) dut (
        .CK(CK), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .stim(stim), .resp(resp), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pattern(rec_pattern), .rec_resp(rec_resp), .busy(busy), .done(done),
        .signature(signature)
    );

    pattern_sweep_capture #(.IN_W(3), .OUT_W(2), .SETTLE(3), .SIG_W(16)) dut2 (
        .CK(CK), .reset(reset), .start(start2), .mode(mode2), .abort(abort2),
        .stim(stim2), .resp(resp2), .rec_valid(rec_valid2), .rec_ready(rec_ready2),
        .rec_pattern(rec_pattern2), .rec_resp(rec_resp2), .busy(busy2), .done(done2),
        .signature(signature2)
    );

    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    function automatic logic [15:0] exp_sig(input int n, input logic m, input int flip);
        logic [15:0] s;
        int p;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            p = m ? (i ^ (i >> 1)) : i;
            s = mstep(s, {15'd0, (p == 7) ^ (p == flip)});
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run1(input logic m, input int stall_pat, input int stall_n, input int glitch_cyc);
        int cyc, left;
        logic [2:0] s_stim, s_pat;
        logic s_resp;
        logic [15:0] s_sig;
        bit snap;
        n_rec = 0; done_cyc = -1; left = stall_n; stall_bad = 0; snap = 0; n_stall = 0;
        mode = m; start = 1; rec_ready = 1;
        tick();
        start = 0; mode = !m;
        sig_start = signature;
        cyc = 0;
        while (cyc < 100 && done_cyc < 0) begin
            start = (cyc == glitch_cyc);
            rec_ready = 1;
            if (rec_valid && left > 0 && stall_pat >= 0 && rec_pattern == 3'(stall_pat)) begin
                if (!snap) begin
                    snap = 1; s_stim = stim; s_pat = rec_pattern; s_resp = rec_resp; s_sig = signature;
                    if (s_pat !== 3'(stall_pat) || s_stim !== 3'(stall_pat)) stall_bad = 1;
                end else if (stim !== s_stim || rec_pattern !== s_pat || rec_resp !== s_resp || signature !== s_sig)
                    stall_bad = 1;
                left--; n_stall++; rec_ready = 0;
            end
            if (rec_valid && rec_ready && n_rec < 8) begin
                pats[n_rec] = rec_pattern;
                rsps[n_rec] = {1'b0, rec_resp};
                n_rec++;
            end
            tick();
            cyc++;
            if (done) done_cyc = cyc;
        end
        start = 0;
        busy_at_done = busy;
        sig_at_done = signature;
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || rec_valid !== 1'b0) $display("FAIL reset_ctrl: busy/done/valid %b%b%b want 000", busy, done, rec_valid); else n_pass++;
        n_total++; if (stim !== 3'd0 || rec_pattern !== 3'd0 || rec_resp !== 1'b0) $display("FAIL reset_data: stim %h pat %h resp %h want 0", stim, rec_pattern, rec_resp); else n_pass++;
        n_total++; if (signature !== 16'h0000) $display("FAIL reset_sig: got %h want 0000", signature); else n_pass++;
        #20 reset = 1;
        tick(); tick();
    endtask

    task automatic test_binary();
        run1(0, -1, 0, -1);
        n_total++; if (sig_start !== 16'hFFFF) $display("FAIL bin_seed: got %h want ffff", sig_start); else n_pass++;
        n_total++; if (n_rec !== 8) $display("FAIL bin_count: got %0d want 8", n_rec); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (pats[i] !== 3'(i) || rsps[i] !== {1'b0, i == 7}) $display("FAIL bin_rec%0d: pat %h resp %h want %h %h", i, pats[i], rsps[i], i, i == 7); else n_pass++;
        end
        n_total++; if (done_cyc !== 16) $display("FAIL bin_done_cyc: got %0d want 16", done_cyc); else n_pass++;
        n_total++; if (busy_at_done !== 1'b0 || done_after !== 1'b0) $display("FAIL bin_busy_done: busy %b next done %b want 0 0", busy_at_done, done_after); else n_pass++;
        n_total++; if (sig_at_done !== exp_sig(8, 0, -1)) $display("FAIL bin_sig: got %h want %h", sig_at_done, exp_sig(8, 0, -1)); else n_pass++;
    endtask

    task automatic test_gray();
        run1(1, -1, 0, -1);
        n_total++; if (n_rec !== 8) $display("FAIL gray_count: got %0d want 8", n_rec); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (pats[i] !== 3'(gray_tab[i]) || rsps[i] !== {1'b0, gray_tab[i] == 7}) $display("FAIL gray_rec%0d: pat %h resp %h want %h", i, pats[i], rsps[i], gray_tab[i]); else n_pass++;
            if (i > 0) begin
                n_total++; if ($countones(pats[i] ^ pats[i-1]) != 1) $display("FAIL gray_step%0d: %h -> %h want one bit", i, pats[i-1], pats[i]); else n_pass++;
            end
        end
        n_total++; if (done_cyc !== 16) $display("FAIL gray_done_cyc: got %0d want 16", done_cyc); else n_pass++;
        n_total++; if (sig_at_done !== exp_sig(8, 1, -1)) $display("FAIL gray_sig: got %h want %h", sig_at_done, exp_sig(8, 1, -1)); else n_pass++;
    endtask

    task automatic test_backpressure();
        run1(0, 3, 5, -1);
        n_total++; if (n_stall !== 5 || stall_bad !== 1'b0) $display("FAIL bp_hold: stalls %0d unstable %b want 5 0", n_stall, stall_bad); else n_pass++;
        n_total++; if (done_cyc !== 21) $display("FAIL bp_done_cyc: got %0d want 21", done_cyc); else n_pass++;
        n_total++; if (pats[3] !== 3'd3 || pats[4] !== 3'd4) $display("FAIL bp_order: got %h %h want 3 4", pats[3], pats[4]); else n_pass++;
        n_total++; if (sig_at_done !== exp_sig(8, 0, -1)) $display("FAIL bp_sig: got %h want %h", sig_at_done, exp_sig(8, 0, -1)); else n_pass++;
    endtask

    task automatic test_settle();
        int cyc;
        logic [15:0] s;
        n_rec = 0; done_cyc = -1; s = 16'hFFFF;
        start2 = 1;
        tick();
        start2 = 0;
        cyc = 0;
        while (cyc < 100 && done_cyc < 0) begin
            if (rec_valid2 && n_rec < 8) begin
                pats[n_rec] = rec_pattern2;
                rsps[n_rec] = rec_resp2;
                n_rec++;
            end
            tick();
            cyc++;
            if (done2) done_cyc = cyc;
        end
        n_total++; if (n_rec !== 8) $display("FAIL settle_count: got %0d want 8", n_rec); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            s = mstep(s, {14'd0, core2(3'(i))});
            n_total++; if (pats[i] !== 3'(i) || rsps[i] !== core2(3'(i))) $display("FAIL settle_rec%0d: pat %h resp %h want %h %h", i, pats[i], rsps[i], i, core2(3'(i))); else n_pass++;
        end
        n_total++; if (done_cyc !== 32) $display("FAIL settle_done_cyc: got %0d want 32", done_cyc); else n_pass++;
        n_total++; if (signature2 !== s) $display("FAIL settle_sig: got %h want %h", signature2, s); else n_pass++;
        tick();
    endtask

    task automatic test_abort_restart();
        int k, dones;
        mode = 0; start = 1; rec_ready = 1;
        tick();
        start = 0;
        for (k = 0; k < 40 && !(rec_valid && rec_pattern == 3'd4); k++) tick();
        abort = 1;
        tick();
        abort = 0;
        n_total++; if (busy !== 1'b0 || rec_valid !== 1'b0 || done !== 1'b0) $display("FAIL abort_ctrl: busy/valid/done %b%b%b want 000", busy, rec_valid, done); else n_pass++;
        n_total++; if (stim !== 3'd0) $display("FAIL abort_stim: got %h want 0", stim); else n_pass++;
        n_total++; if (signature !== exp_sig(4, 0, -1)) $display("FAIL abort_sig: got %h want %h", signature, exp_sig(4, 0, -1)); else n_pass++;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dones++;
        end
        n_total++; if (dones !== 0 || busy !== 1'b0) $display("FAIL abort_idle: dones %0d busy %b want 0 0", dones, busy); else n_pass++;
        run1(0, -1, 0, 5);
        n_total++; if (sig_start !== 16'hFFFF) $display("FAIL restart_seed: got %h want ffff", sig_start); else n_pass++;
        n_total++; if (n_rec !== 8 || pats[0] !== 3'd0 || pats[7] !== 3'd7) $display("FAIL restart_recs: n %0d first %h last %h want 8 0 7", n_rec, pats[0], pats[7]); else n_pass++;
        n_total++; if (done_cyc !== 16) $display("FAIL restart_done_cyc: got %0d want 16", done_cyc); else n_pass++;
        n_total++; if (sig_at_done !== exp_sig(8, 0, -1)) $display("FAIL restart_sig: got %h want %h", sig_at_done, exp_sig(8, 0, -1)); else n_pass++;
    endtask

    task automatic test_signature();
        logic [15:0] sig_a, sig_b;
        run1(0, -1, 0, -1);
        sig_a = sig_at_done;
        run1(0, -1, 0, -1);
        sig_b = sig_at_done;
        n_total++; if (sig_a !== sig_b) $display("FAIL sig_repeat: got %h and %h want equal", sig_a, sig_b); else n_pass++;
        n_total++; if (sig_b !== exp_sig(8, 0, -1)) $display("FAIL sig_model: got %h want %h", sig_b, exp_sig(8, 0, -1)); else n_pass++;
        inject = 1;
        run1(0, -1, 0, -1);
        inject = 0;
        n_total++; if (sig_at_done === sig_a) $display("FAIL sig_flip_diff: got %h want different from %h", sig_at_done, sig_a); else n_pass++;
        n_total++; if (sig_at_done !== exp_sig(8, 0, 5)) $display("FAIL sig_flip_model: got %h want %h", sig_at_done, exp_sig(8, 0, 5)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dones;
        mode = 0; start = 1; rec_ready = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 0;
        #1;
        n_total++; if (busy !== 1'b0 || rec_valid !== 1'b0 || done !== 1'b0) $display("FAIL rmid_ctrl: busy/valid/done %b%b%b want 000", busy, rec_valid, done); else n_pass++;
        n_total++; if (stim !== 3'd0 || rec_pattern !== 3'd0 || rec_resp !== 1'b0 || signature !== 16'h0000) $display("FAIL rmid_data: stim %h pat %h resp %h sig %h want 0", stim, rec_pattern, rec_resp, signature); else n_pass++;
        #10 reset = 1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL rmid_after: %0d active cycles want 0", dones); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_backpressure();
        test_settle();
        test_abort_restart();
        test_signature();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
